// File: rtl/etcpu_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited imem requests and buffers responses for decode.
// Optional ETCPU_FQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module etcpu_fetch_queue #(
   parameter int                 DAT_W      = 32,
   parameter int                 ADDR_W     = 32,
   parameter int                 DEPTH      = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC   = {ADDR_W{1'b0}},
   parameter int                 INST_BYTES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        imem_req,
   output logic [ADDR_W-1:0]           imem_addr,
   input  logic                        imem_gnt,
   input  logic                        imem_rvalid,
   input  logic [DAT_W-1:0]            imem_rdata,
   output logic                        id_valid,
   output logic [DAT_W-1:0]            id_inst,
   output logic [ADDR_W-1:0]           id_pc,
   input  logic                        id_ready,
   input  logic                        flush,
   input  logic [ADDR_W-1:0]           flush_pc,
   output logic [$clog2(DEPTH+1)-1:0]  fq_level
);

   localparam int                CNT_W    = $clog2(DEPTH + 1);
   localparam int                PTR_W    = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(INST_BYTES);
   localparam logic [CNT_W:0]    CREDITS  = (CNT_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
   localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1'b1);

   logic [ADDR_W-1:0] fetch_pc_r;
   logic [ADDR_W-1:0] rsp_pc_r;
   logic [CNT_W-1:0]  outstanding_r;
   logic [CNT_W-1:0]  drop_cnt_r;
   logic [CNT_W-1:0]  count_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [DAT_W-1:0]  inst_mem_r [DEPTH];
   logic [ADDR_W-1:0] pc_mem_r   [DEPTH];

   logic              req_s;
   logic              accept_s;
   logic              rsp_keep_s;
   logic              push_s;
   logic              pop_s;
   logic              fifo_nempty_s;
   logic [CNT_W-1:0]  outstanding_nxt_s;
`ifdef ETCPU_FQ_BYPASS_EN
   logic              bypass_s;
`endif

   // Credit check, handshake qualification and decode-side presentation.
   always_comb begin
      fifo_nempty_s     = !rst && (count_r != CNT_ZERO);
      req_s             = !rst && !flush &&
                          (({1'b0, count_r} + {1'b0, outstanding_r}) < CREDITS);
      accept_s          = req_s && imem_gnt;
      outstanding_nxt_s = outstanding_r + CNT_W'(accept_s) - CNT_W'(imem_rvalid);
      rsp_keep_s        = !rst && !flush && imem_rvalid && (drop_cnt_r == CNT_ZERO);
      pop_s             = fifo_nempty_s && id_ready && !flush;
`ifdef ETCPU_FQ_BYPASS_EN
      bypass_s          = rsp_keep_s && (count_r == CNT_ZERO);
      push_s            = rsp_keep_s && !(bypass_s && id_ready);
      id_valid          = fifo_nempty_s || bypass_s;
      if (bypass_s) begin
         id_inst = imem_rdata;
         id_pc   = rsp_pc_r;
      end else begin
         id_inst = inst_mem_r[rd_ptr_r];
         id_pc   = pc_mem_r[rd_ptr_r];
      end
`else
      push_s            = rsp_keep_s;
      id_valid          = fifo_nempty_s;
      id_inst           = inst_mem_r[rd_ptr_r];
      id_pc             = pc_mem_r[rd_ptr_r];
`endif
   end

   assign imem_req  = req_s;
   assign imem_addr = fetch_pc_r;
   assign fq_level  = count_r;

   // Control state: PCs, credits, drop counter and queue pointers; flush wins over everything but rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_r    <= RESET_PC;
         rsp_pc_r      <= RESET_PC;
         outstanding_r <= CNT_ZERO;
         drop_cnt_r    <= CNT_ZERO;
         count_r       <= CNT_ZERO;
         rd_ptr_r      <= PTR_ZERO;
         wr_ptr_r      <= PTR_ZERO;
      end else begin
         outstanding_r <= outstanding_nxt_s;
         if (flush) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_r <= flush_pc;
            rsp_pc_r   <= flush_pc;
            drop_cnt_r <= outstanding_nxt_s;
            count_r    <= CNT_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
         end else begin
            if (accept_s) begin
               fetch_pc_r <= fetch_pc_r + PC_INC;
            end
            if (imem_rvalid) begin
               if (drop_cnt_r != CNT_ZERO) begin
                  drop_cnt_r <= drop_cnt_r - CNT_ONE;
               end else begin
                  rsp_pc_r <= rsp_pc_r + PC_INC;
               end
            end
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
         end
      end
   end

   // Queue storage; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         inst_mem_r[wr_ptr_r] <= imem_rdata;
         pc_mem_r[wr_ptr_r]   <= rsp_pc_r;
      end
   end

   etcpu_fetch_queue_chk #(.CNT_W(CNT_W)) u_chk (
      .clk         (clk),
      .rst         (rst),
      .imem_rvalid (imem_rvalid),
      .outstanding (outstanding_r)
   );

endmodule

// A response with nothing outstanding means the memory side broke the protocol.
module etcpu_fetch_queue_chk #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             imem_rvalid,
   input  logic [CNT_W-1:0] outstanding
);

   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
      (!imem_rvalid || (outstanding != {CNT_W{1'b0}})));

endmodule

// File: tb/tb_etcpu_fetch_queue.sv
// Directed bench for etcpu_fetch_queue: variable-latency memory model plus in-order PC/instruction scoreboard.
module tb_etcpu_fetch_queue;

   localparam int DAT_W  = 32;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic        id_ready = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = 32'h0;
   logic [2:0]  fq_level;

   always #5 clk = ~clk;

   etcpu_fetch_queue #(
      .DAT_W(DAT_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0), .INST_BYTES(4)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready),
      .flush(flush), .flush_pc(flush_pc), .fq_level(fq_level)
   );

   logic        rst_v, gnt_v, ready_v, flush_v;
   logic [31:0] flush_pc_v;
   int          lat;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          acc_cnt, pop_cnt;
   logic [31:0] exp_addr, exp_pc, last_acc_addr, last_pop_pc;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0200) return 32'h00A0_0093;
      return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: drive inputs on the falling edge, model memory, sample and score before the rising edge.
   task automatic step();
      @(negedge clk);
      rst         = rst_v;
      imem_gnt    = gnt_v;
      id_ready    = ready_v;
      flush       = flush_v;
      flush_pc    = flush_pc_v;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend_addr[0]);
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end
      #1;
      check_val("fq_bound", 32'(fq_level <= 3'd4), 32'd1);
      if (rst_v) begin
         check_val("rst_req", 32'(imem_req), 32'd0);
         exp_addr = 32'h0;
         exp_pc   = 32'h0;
      end else begin
         if (imem_req && imem_gnt) begin
            check_val("req_addr", imem_addr, exp_addr);
            last_acc_addr = imem_addr;
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
            exp_addr += 32'd4;
            acc_cnt++;
         end
         if (flush_v) begin
            check_val("flush_req", 32'(imem_req), 32'd0);
            exp_addr = flush_pc_v;
            exp_pc   = flush_pc_v;
         end else if (id_valid && id_ready) begin
            check_val("pop_pc", id_pc, exp_pc);
            check_val("pop_inst", id_inst, mem_word(exp_pc));
            last_pop_pc = id_pc;
            exp_pc += 32'd4;
            pop_cnt++;
         end
      end
      cyc++;
   endtask

   task automatic quiesce();
      gnt_v   = 1'b0;
      ready_v = 1'b1;
      flush_v = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (pend_addr.size() == 0 && !imem_rvalid && fq_level == 3'd0) break;
      end
      check_val("quiesce_level", 32'(fq_level), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_v = 1'b1; gnt_v = 1'b1; ready_v = 1'b1; flush_v = 1'b0; flush_pc_v = 32'h0;
      lat = 1; exp_addr = 32'h0; exp_pc = 32'h0; acc_cnt = 0; pop_cnt = 0;
      last_acc_addr = 32'h0; last_pop_pc = 32'h0;

      // Reset state
      step(); step();
      check_val("rst_req_out", 32'(imem_req), 32'd0);
      check_val("rst_valid", 32'(id_valid), 32'd0);
      check_val("rst_level", 32'(fq_level), 32'd0);

      // Streaming at latency 1, decode always ready
      rst_v = 1'b0; acc_cnt = 0; pop_cnt = 0;
      repeat (12) step();
      check_val("t1_accepts", 32'(acc_cnt), 32'd12);
      check_val("t1_pops", 32'(pop_cnt), 32'd10);

      // Decode interlock: queue fills to DEPTH and requests stop
      quiesce();
      gnt_v = 1'b1; ready_v = 1'b0; acc_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (id_valid) check_val("t2_head_hold", id_pc, exp_pc);
      end
      check_val("t2_accepts", 32'(acc_cnt), 32'd4);
      check_val("t2_req_low", 32'(imem_req), 32'd0);
      check_val("t2_level", 32'(fq_level), 32'd4);
      ready_v = 1'b1; acc_cnt = 0; pop_cnt = 0;
      repeat (4) step();
      check_val("t2_pops", 32'(pop_cnt), 32'd4);
      check_val("t2_resume", 32'(acc_cnt), 32'd3);

      // Flush with three requests in flight at latency 3
      quiesce();
      lat = 3; gnt_v = 1'b1; ready_v = 1'b0; acc_cnt = 0;
      repeat (3) step();
      check_val("t3_inflight", 32'(acc_cnt), 32'd3);
      flush_v = 1'b1; flush_pc_v = 32'h0000_0100;
      step();
      flush_v = 1'b0; ready_v = 1'b1; acc_cnt = 0; pop_cnt = 0;
      step();
      check_val("t3_drop_cnt", 32'(dut.drop_cnt_r), 32'd2);
      check_val("t3_redirect", last_acc_addr, 32'h0000_0100);
      check_val("t3_acc", 32'(acc_cnt), 32'd1);
      for (int i = 0; i < 20 && pop_cnt == 0; i++) step();
      check_val("t3_first_pop", last_pop_pc, 32'h0000_0100);

      // Flush colliding with a response and a pop
      quiesce();
      lat = 2; gnt_v = 1'b1; ready_v = 1'b1;
      repeat (6) step();
      check_val("t4_pre_valid", 32'(id_valid), 32'd1);
      flush_v = 1'b1; flush_pc_v = 32'h0000_0300;
      step();
      flush_v = 1'b0; gnt_v = 1'b0;
      step();
      check_val("t4_valid", 32'(id_valid), 32'd0);
      check_val("t4_level", 32'(fq_level), 32'd0);
      check_val("t4_drop_cnt", 32'(dut.drop_cnt_r), 32'd1);

      // PC wrap at the top of the address space
      quiesce();
      lat = 1; gnt_v = 1'b1; ready_v = 1'b1;
      flush_v = 1'b1; flush_pc_v = 32'hFFFF_FFFC;
      step();
      flush_v = 1'b0;
      step();
      check_val("t5_top", last_acc_addr, 32'hFFFF_FFFC);
      step();
      check_val("t5_wrap", last_acc_addr, 32'h0000_0000);

      // Reset pulse with a populated queue
      ready_v = 1'b0;
      repeat (3) step();
      gnt_v = 1'b0;
      repeat (4) step();
      check_val("t5_pre_valid", 32'(id_valid), 32'd1);
      rst_v = 1'b1; gnt_v = 1'b1;
      step();
      check_val("t5_rst_valid", 32'(id_valid), 32'd0);
      step();
      check_val("t5_rst_level", 32'(fq_level), 32'd0);
      rst_v = 1'b0; ready_v = 1'b1; acc_cnt = 0; last_acc_addr = 32'hDEAD_BEEF;
      step();
      check_val("t5_rst_acc", 32'(acc_cnt), 32'd1);
      check_val("t5_rst_addr", last_acc_addr, 32'h0000_0000);

      // Single response into an empty queue
      quiesce();
      lat = 1; gnt_v = 1'b0; ready_v = 1'b1;
      flush_v = 1'b1; flush_pc_v = 32'h0000_0200;
      step();
      flush_v = 1'b0; gnt_v = 1'b1;
      step();
      gnt_v = 1'b0;
      step();
`ifdef ETCPU_FQ_BYPASS_EN
      check_val("t6_byp_valid", 32'(id_valid), 32'd1);
      check_val("t6_byp_inst", id_inst, 32'h00A0_0093);
      check_val("t6_byp_level", 32'(fq_level), 32'd0);
      step();
      check_val("t6_after_valid", 32'(id_valid), 32'd0);
      check_val("t6_after_level", 32'(fq_level), 32'd0);
`else
      check_val("t6_rsp_valid", 32'(id_valid), 32'd0);
      step();
      check_val("t6_next_valid", 32'(id_valid), 32'd1);
      check_val("t6_next_inst", id_inst, 32'h00A0_0093);
      check_val("t6_next_level", 32'(fq_level), 32'd1);
      step();
      check_val("t6_after_valid", 32'(id_valid), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
